uart_rx_oversampled: RTL and testbench
======================================

# uart_rx_oversampled

UART receiver that deserializes the asynchronous `rx` line into bytes using the 16x-oversampling `tick` from `baud_rate_generator`. Frames are 8N1: one start bit, DATA_BITS data bits LSB-first, one stop bit, no parity. Received words go to the downstream consumer (command decoder / FIFO) over a valid/ready handshake, with sticky-free error pulses for framing and overrun.

## Interface
- DATA_BITS, 8, data bits per frame (5..8)
- OVERSAMPLE, 16, ticks per bit period; must match the tick generator
- clk  input  1  system clock
- arst_n  input  1  reset, asynchronous, active-low
- tick  input  1  one-clk pulse at OVERSAMPLE x baud rate
- rx  input  1  asynchronous serial line, idle high
- rx_data  output  DATA_BITS  received word, held stable while rx_valid=1
- rx_valid  output  1  word available
- rx_ready  input  1  consumer accepts word when rx_valid && rx_ready
- busy  output  1  high in any state other than IDLE
- frame_err  output  1  one-clk pulse: stop bit sampled 0
- overrun_err  output  1  one-clk pulse: new word overwrote an unaccepted word

## Operation
- `rx` passes through a 2-FF synchronizer (reset value 1); all decisions use the synchronized value `rx_s`.
- All state/counter activity advances only on clk cycles with tick=1; between ticks state holds.
- Tick counter width $clog2(OVERSAMPLE); bit counter width $clog2(DATA_BITS+1).
- States:
  - IDLE: on a tick with rx_s=0 -> START, tick counter cleared.
  - START: counts ticks; on the tick where counter = OVERSAMPLE/2-1: rx_s=0 -> DATA (counters cleared); rx_s=1 -> IDLE (glitch rejected, no output).
  - DATA: on the tick where counter = OVERSAMPLE-1, shift rx_s into MSB of shift register (LSB-first), counter wraps to 0, bit counter +1; after DATA_BITS samples -> STOP.
  - STOP: on the tick where counter = OVERSAMPLE-1, sample rx_s; 1 -> load rx_data, set rx_valid; 0 -> pulse frame_err, rx_data/rx_valid unchanged. Either case -> IDLE same tick.
- Returning to IDLE at stop-bit middle leaves half a bit of margin to catch the next start edge.
- Overrun: word completes while rx_valid=1 and no handshake that cycle -> rx_data overwritten with new word, overrun_err pulses, rx_valid stays 1.
- Handshake: rx_valid && rx_ready -> rx_valid clears next cycle. Handshake and completion in same cycle -> new word loaded, rx_valid stays 1, no overrun_err.
- Framing error with line held low (break): IDLE re-enters START immediately, START sees rx_s=0 and proceeds; each resulting all-zero frame reports frame_err. No special break handling.

## Timing
- Reset values: rx_data=0, rx_valid=0, busy=0, frame_err=0, overrun_err=0, state IDLE, counters 0, synchronizer 1.
- Reset mid-frame aborts immediately; no partial word delivered.
- Let T0 = tick on which IDLE sees rx_s=0. Start verify at tick T0+OVERSAMPLE/2; data bit i (i=0..DATA_BITS-1) at T0+OVERSAMPLE/2+OVERSAMPLE*(i+1); stop at T0+OVERSAMPLE/2+OVERSAMPLE*(DATA_BITS+1) (default T0+152).
- rx_valid / frame_err / overrun_err assert the clk cycle after the stop-sample tick (registered outputs).
- Input-to-detection latency: 2 clk (synchronizer) plus up to one tick period.
- Tolerates baud mismatch up to ~±3% over a 10-bit frame at OVERSAMPLE=16.
- busy asserts the cycle after T0, deasserts the cycle after the stop-sample tick.

## Test plan
- Nominal: CLK_FREQ 50 MHz, tick period 325 clk, drive 0xA5 at 9600 baud, rx_ready=1 -> rx_data=0xA5, rx_valid high exactly one cycle, no errors.
- Glitch: rx low for 3 ticks then high -> returns to IDLE, busy drops, no rx_valid, no frame_err.
- Framing: send 0x3C with stop bit 0 -> frame_err one-cycle pulse, rx_valid stays 0, rx_data keeps prior value.
- Overrun: rx_ready=0, send 0x11 then 0x22 -> rx_valid stays 1, overrun_err pulses at second stop sample, rx_data=0x22.
- Back-to-back: 0x00, 0xFF, 0x55 with no idle gap, rx_ready=1 -> three words in order, no errors; also handshake coinciding with completion -> no overrun_err.
- Reset: assert arst_n low mid-DATA of 0x99 then release, send 0x42 -> all outputs 0 during reset, next word 0x42 only.

Source files
------------

// File: rtl/uart_rx_oversampled.sv
// -----------------------------------------------------------------------------
// uart_rx_oversampled
//   UART receiver for 8N1-style frames (one start bit, DATA_BITS data bits
//   LSB-first, one stop bit, no parity). It samples the line at the middle of
//   each bit using a OVERSAMPLE x baud tick from the baud rate generator.
//   Received words are offered on a valid/ready handshake.
//
// Ports
//   clk          system clock
//   arst_n       asynchronous active-low reset
//   tick         one-clk pulse at OVERSAMPLE x baud rate
//   rx           asynchronous serial line, idle high
//   rx_data      received word, held stable while rx_valid=1
//   rx_valid     word available
//   rx_ready     consumer accepts the word when rx_valid && rx_ready
//   busy         high whenever the receiver is not idle
//   frame_err    one-clk pulse: stop bit sampled low
//   overrun_err  one-clk pulse: a new word replaced an unaccepted word
// -----------------------------------------------------------------------------
module uart_rx_oversampled #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 overrun_err
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_END  = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_ZERO = TW'(0);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] BIT_ZERO  = BW'(0);
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    logic [1:0]           sync_r;
    logic                 rx_s;
    state_t               state_r,    state_nxt_s;
    logic [TW-1:0]        tick_cnt_r, tick_cnt_nxt_s;
    logic [BW-1:0]        bit_cnt_r,  bit_cnt_nxt_s;
    logic [DATA_BITS-1:0] shift_r,    shift_nxt_s;
    logic                 word_done_s;
    logic                 stop_bad_s;

    logic [DATA_BITS-1:0] rx_data_r,     rx_data_nxt_s;
    logic                 rx_valid_r,    rx_valid_nxt_s;
    logic                 busy_r,        busy_nxt_s;
    logic                 frame_err_r,   frame_err_nxt_s;
    logic                 overrun_err_r, overrun_err_nxt_s;

    // Two-flop synchronizer for the asynchronous line; resets to idle level.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], rx};
        end
    end

    assign rx_s = sync_r[1];

    // State, counter, shift register and registered-output flops.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_r       <= ST_IDLE;
            tick_cnt_r    <= TICK_ZERO;
            bit_cnt_r     <= BIT_ZERO;
            shift_r       <= {DATA_BITS{1'b0}};
            rx_data_r     <= {DATA_BITS{1'b0}};
            rx_valid_r    <= 1'b0;
            busy_r        <= 1'b0;
            frame_err_r   <= 1'b0;
            overrun_err_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            tick_cnt_r    <= tick_cnt_nxt_s;
            bit_cnt_r     <= bit_cnt_nxt_s;
            shift_r       <= shift_nxt_s;
            rx_data_r     <= rx_data_nxt_s;
            rx_valid_r    <= rx_valid_nxt_s;
            busy_r        <= busy_nxt_s;
            frame_err_r   <= frame_err_nxt_s;
            overrun_err_r <= overrun_err_nxt_s;
        end
    end

    // Next-state logic: everything advances only on tick cycles.
    always_comb begin
        state_nxt_s    = state_r;
        tick_cnt_nxt_s = tick_cnt_r;
        bit_cnt_nxt_s  = bit_cnt_r;
        shift_nxt_s    = shift_r;
        word_done_s    = 1'b0;
        stop_bad_s     = 1'b0;
        if (tick) begin
            case (state_r)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_nxt_s    = ST_START;
                        tick_cnt_nxt_s = TICK_ZERO;
                    end else begin
                        state_nxt_s    = ST_IDLE;
                    end
                end
                ST_START: begin
                    // Re-check the line half a bit in to reject short glitches.
                    if (tick_cnt_r == TICK_MID) begin
                        if (!rx_s) begin
                            state_nxt_s    = ST_DATA;
                            tick_cnt_nxt_s = TICK_ZERO;
                            bit_cnt_nxt_s  = BIT_ZERO;
                        end else begin
                            state_nxt_s    = ST_IDLE;
                        end
                    end else begin
                        tick_cnt_nxt_s = tick_cnt_r + TICK_ONE;
                    end
                end
                ST_DATA: begin
                    if (tick_cnt_r == TICK_END) begin
                        // LSB arrives first, so shift in at the top.
                        shift_nxt_s    = {rx_s, shift_r[DATA_BITS-1:1]};
                        tick_cnt_nxt_s = TICK_ZERO;
                        bit_cnt_nxt_s  = bit_cnt_r + BIT_ONE;
                        if (bit_cnt_r == BIT_LAST) begin
                            state_nxt_s = ST_STOP;
                        end else begin
                            state_nxt_s = ST_DATA;
                        end
                    end else begin
                        tick_cnt_nxt_s = tick_cnt_r + TICK_ONE;
                    end
                end
                ST_STOP: begin
                    // Leave at mid stop bit so half a bit remains to catch the
                    // next start edge.
                    if (tick_cnt_r == TICK_END) begin
                        state_nxt_s    = ST_IDLE;
                        tick_cnt_nxt_s = TICK_ZERO;
                        if (rx_s) begin
                            word_done_s = 1'b1;
                        end else begin
                            stop_bad_s  = 1'b1;
                        end
                    end else begin
                        tick_cnt_nxt_s = tick_cnt_r + TICK_ONE;
                    end
                end
                default: begin
                    state_nxt_s    = ST_IDLE;
                    tick_cnt_nxt_s = TICK_ZERO;
                    bit_cnt_nxt_s  = BIT_ZERO;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Output logic: word delivery, handshake, and error pulses.
    always_comb begin
        rx_data_nxt_s     = rx_data_r;
        rx_valid_nxt_s    = rx_valid_r;
        frame_err_nxt_s   = stop_bad_s;
        overrun_err_nxt_s = 1'b0;
        busy_nxt_s        = (state_nxt_s != ST_IDLE);
        if (word_done_s) begin
            // A handshake in the completion cycle frees the slot, so no overrun.
            rx_data_nxt_s     = shift_r;
            rx_valid_nxt_s    = 1'b1;
            overrun_err_nxt_s = rx_valid_r & ~rx_ready;
        end else if (rx_valid_r && rx_ready) begin
            rx_valid_nxt_s    = 1'b0;
        end else begin
            rx_valid_nxt_s    = rx_valid_r;
        end
    end

    assign rx_data     = rx_data_r;
    assign rx_valid    = rx_valid_r;
    assign busy        = busy_r;
    assign frame_err   = frame_err_r;
    assign overrun_err = overrun_err_r;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_oversampled
//   Self-checking bench for uart_rx_oversampled. Frames are driven bit by bit;
//   expected words go into a scoreboard queue when a frame is driven and are
//   popped and compared whenever the DUT completes a handshake. Error pulses,
//   valid cycles and busy cycles are counted by the monitor and compared per
//   scenario. The tick period is kept short so the whole run stays small.
// -----------------------------------------------------------------------------
module tb_uart_rx_oversampled;

    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;
    localparam int TICK_DIV   = 4;
    localparam int BIT_CLKS   = OVERSAMPLE * TICK_DIV;
    localparam int STOP_TICK  = OVERSAMPLE / 2 + OVERSAMPLE * (DATA_BITS + 1);

    logic                 clk      = 1'b0;
    logic                 arst_n   = 1'b0;
    logic                 tick     = 1'b0;
    logic                 rx       = 1'b1;
    logic                 rx_ready = 1'b0;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 busy;
    logic                 frame_err;
    logic                 overrun_err;

    int n_cmp = 0;
    int n_err = 0;
    int valid_cycles = 0;
    int fe_cycles    = 0;
    int ov_cycles    = 0;
    int busy_cycles  = 0;
    int tick_div_cnt = 0;
    logic [DATA_BITS-1:0] exp_q[$];

    uart_rx_oversampled #(
        .DATA_BITS  (DATA_BITS),
        .OVERSAMPLE (OVERSAMPLE)
    ) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .tick        (tick),
        .rx          (rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .busy        (busy),
        .frame_err   (frame_err),
        .overrun_err (overrun_err)
    );

    always #5 clk = ~clk;

    // Free-running tick: one clk high every TICK_DIV clks.
    always @(posedge clk) begin
        if (tick_div_cnt == TICK_DIV - 1) begin
            tick_div_cnt <= 0;
            tick         <= 1'b1;
        end else begin
            tick_div_cnt <= tick_div_cnt + 1;
            tick         <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: counts output activity and pops the scoreboard on handshakes.
    initial begin
        forever begin
            @(negedge clk);
            if (arst_n) begin
                if (rx_valid)    valid_cycles++;
                if (frame_err)   fe_cycles++;
                if (overrun_err) ov_cycles++;
                if (busy)        busy_cycles++;
                if (rx_valid && rx_ready) begin
                    check("sb_word_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        check("sb_word", 32'(rx_data), 32'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    // Drive the line at level v for n clks, ending 1 time unit after an edge.
    task automatic hold_line(input logic v, input int n);
        rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        logic [7:0] b;
        b = d;
        hold_line(1'b0, BIT_CLKS);
        for (int i = 0; i < DATA_BITS; i++) begin
            hold_line(b[i], BIT_CLKS);
        end
        hold_line(stop_bit, BIT_CLKS);
        rx = 1'b1;
    endtask

    // Locate the stop-sample tick from the busy rise (cycle after T0) and
    // return positioned at the start of that tick cycle.
    task automatic wait_stop_tick(output bit ok);
        int guard;
        int ticks;
        guard = 0;
        ticks = 0;
        while (!busy && guard < 4 * BIT_CLKS) begin
            @(negedge clk);
            guard++;
        end
        while (ticks < STOP_TICK - 1 && guard < 20 * BIT_CLKS) begin
            @(negedge clk);
            guard++;
            if (tick) ticks++;
        end
        while (ticks < STOP_TICK && guard < 20 * BIT_CLKS) begin
            @(posedge clk);
            #1;
            guard++;
            if (tick) ticks++;
        end
        ok = (ticks == STOP_TICK);
    endtask

    initial begin
        int v0, f0, o0, b0;
        bit ok;

        // Reset state.
        arst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_data",     32'(rx_data),     32'd0);
        check("rst_rx_valid",    32'(rx_valid),    32'd0);
        check("rst_busy",        32'(busy),        32'd0);
        check("rst_frame_err",   32'(frame_err),   32'd0);
        check("rst_overrun_err", 32'(overrun_err), 32'd0);
        arst_n   = 1'b1;
        rx_ready = 1'b1;
        hold_line(1'b1, 2 * BIT_CLKS);

        // Nominal word.
        v0 = valid_cycles; f0 = fe_cycles; o0 = ov_cycles;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        hold_line(1'b1, 2 * BIT_CLKS);
        check("nom_valid_cycles", 32'(valid_cycles - v0), 32'd1);
        check("nom_frame_err",    32'(fe_cycles - f0),    32'd0);
        check("nom_overrun_err",  32'(ov_cycles - o0),    32'd0);
        check("nom_rx_data",      32'(rx_data),           32'hA5);
        check("nom_sb_drained",   32'(exp_q.size()),      32'd0);

        // Glitch: low for 3 ticks only.
        v0 = valid_cycles; f0 = fe_cycles; b0 = busy_cycles;
        hold_line(1'b0, 3 * TICK_DIV);
        hold_line(1'b1, BIT_CLKS);
        check("glitch_busy_seen",  32'(busy_cycles != b0), 32'd1);
        check("glitch_busy_idle",  32'(busy),              32'd0);
        check("glitch_no_valid",   32'(valid_cycles - v0), 32'd0);
        check("glitch_no_ferr",    32'(fe_cycles - f0),    32'd0);

        // Framing error: stop bit low.
        v0 = valid_cycles; f0 = fe_cycles;
        send_frame(8'h3C, 1'b0);
        hold_line(1'b1, 2 * BIT_CLKS);
        check("frame_err_cycles", 32'(fe_cycles - f0),    32'd1);
        check("frame_no_valid",   32'(valid_cycles - v0), 32'd0);
        check("frame_rx_valid",   32'(rx_valid),          32'd0);
        check("frame_rx_data",    32'(rx_data),           32'hA5);

        // Overrun: consumer stalled across two words.
        rx_ready = 1'b0;
        o0 = ov_cycles;
        send_frame(8'h11, 1'b1);
        hold_line(1'b1, BIT_CLKS);
        check("ovr_first_no_err", 32'(ov_cycles - o0), 32'd0);
        exp_q.push_back(8'h22);
        send_frame(8'h22, 1'b1);
        hold_line(1'b1, BIT_CLKS);
        @(negedge clk);
        check("ovr_err_cycles", 32'(ov_cycles - o0), 32'd1);
        check("ovr_rx_valid",   32'(rx_valid),        32'd1);
        check("ovr_rx_data",    32'(rx_data),         32'h22);
        @(posedge clk);
        #1;
        rx_ready = 1'b1;
        hold_line(1'b1, BIT_CLKS);
        check("ovr_sb_drained", 32'(exp_q.size()), 32'd0);

        // Back-to-back frames with no idle gap.
        v0 = valid_cycles; f0 = fe_cycles; o0 = ov_cycles;
        exp_q.push_back(8'h00);
        send_frame(8'h00, 1'b1);
        exp_q.push_back(8'hFF);
        send_frame(8'hFF, 1'b1);
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1);
        hold_line(1'b1, 2 * BIT_CLKS);
        check("b2b_valid_cycles", 32'(valid_cycles - v0), 32'd3);
        check("b2b_frame_err",    32'(fe_cycles - f0),    32'd0);
        check("b2b_overrun_err",  32'(ov_cycles - o0),    32'd0);
        check("b2b_sb_drained",   32'(exp_q.size()),      32'd0);

        // Handshake in the same cycle as the next word completes.
        rx_ready = 1'b0;
        o0 = ov_cycles;
        exp_q.push_back(8'h33);
        send_frame(8'h33, 1'b1);
        hold_line(1'b1, 2 * BIT_CLKS);
        exp_q.push_back(8'h44);
        fork
            send_frame(8'h44, 1'b1);
            begin
                wait_stop_tick(ok);
                check("coin_stop_tick_found", 32'(ok), 32'd1);
                rx_ready = 1'b1;
                @(negedge clk);
                check("coin_busy_at_stop", 32'(busy), 32'd1);
                @(posedge clk);
                #1;
                rx_ready = 1'b0;
                @(negedge clk);
                check("coin_busy_after", 32'(busy),           32'd0);
                check("coin_rx_valid",   32'(rx_valid),       32'd1);
                check("coin_rx_data",    32'(rx_data),        32'h44);
                check("coin_no_overrun", 32'(ov_cycles - o0), 32'd0);
            end
        join
        rx_ready = 1'b1;
        hold_line(1'b1, 2 * BIT_CLKS);
        check("coin_sb_drained", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a frame; the aborted word never appears.
        fork
            send_frame(8'h99, 1'b1);
            begin
                repeat (4 * BIT_CLKS) @(posedge clk);
                #1;
                arst_n = 1'b0;
                @(negedge clk);
                check("mid_rst_rx_data",     32'(rx_data),     32'd0);
                check("mid_rst_rx_valid",    32'(rx_valid),    32'd0);
                check("mid_rst_busy",        32'(busy),        32'd0);
                check("mid_rst_frame_err",   32'(frame_err),   32'd0);
                check("mid_rst_overrun_err", 32'(overrun_err), 32'd0);
            end
        join
        arst_n = 1'b1;
        hold_line(1'b1, 2 * BIT_CLKS);
        v0 = valid_cycles; f0 = fe_cycles;
        exp_q.push_back(8'h42);
        send_frame(8'h42, 1'b1);
        hold_line(1'b1, 2 * BIT_CLKS);
        check("post_rst_valid_cycles", 32'(valid_cycles - v0), 32'd1);
        check("post_rst_frame_err",    32'(fe_cycles - f0),    32'd0);
        check("post_rst_rx_data",      32'(rx_data),           32'h42);
        check("final_sb_drained",      32'(exp_q.size()),      32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
